// File: rtl/cry_pkg.sv
// rtl/cry_pkg.sv - shared constants and types for the CRY lookup arbiter
// No ports: NREQ requesters, LUT_AW/LUT_DW ROM geometry, fixed lookup latency, requester-id type.
package cry_pkg;

    localparam int NREQ    = 2;
    localparam int LUT_AW  = 8;
    localparam int LUT_DW  = 8;
    localparam int LATENCY = 3;

    typedef logic [$clog2(NREQ)-1:0] req_id_t;

endpackage

// File: rtl/cry_scale.sv
// rtl/cry_scale.sv - combinational intensity scaling of a ROM colour component
// Ports: rom_z (component from ROM), y (intensity) -> data = (rom_z * (y + 1)) >> 8.
module cry_scale
    import cry_pkg::*;
(
    input  logic [LUT_DW-1:0] rom_z,
    input  logic [7:0]        y,
    output logic [LUT_DW-1:0] data
);

    logic [8:0] y_p1;

    // y + 1 needs 9 bits so that y = 0xFF scales by exactly 256 and returns rom_z
    always_comb begin
        y_p1 = {1'b0, y} + 9'd1;
        data = LUT_DW'(({8'd0, rom_z} * {7'd0, y_p1}) >> 8);
    end

endmodule

// File: rtl/cry_lut_arb.sv
// rtl/cry_lut_arb.sv - two-requester round-robin arbiter onto a shared registered CRY ROM
// Ports: sys_clk/reset_n; per requester N a lookup request (reqN_valid/ready/cr/y) and a
// result response (rspN_valid/ready/data); rom_a/rom_z to the external 256x8 ROM.
module cry_lut_arb
    import cry_pkg::*;
(
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [7:0]        req0_cr,
    input  logic [7:0]        req0_y,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [LUT_DW-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [7:0]        req1_cr,
    input  logic [7:0]        req1_y,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [LUT_DW-1:0] rsp1_data,
    output logic [LUT_AW-1:0] rom_a,
    input  logic [LUT_DW-1:0] rom_z
);

    logic [NREQ-1:0]   busy_q, busy_d;
    req_id_t           last_q, last_d;
    logic              s1_valid_q, s1_valid_d;
    req_id_t           s1_id_q, s1_id_d;
    logic [7:0]        s1_y_q, s1_y_d;
    logic [LUT_AW-1:0] rom_a_q, rom_a_d;
    logic              s2_valid_q, s2_valid_d;
    req_id_t           s2_id_q, s2_id_d;
    logic [7:0]        s2_y_q, s2_y_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [LUT_DW-1:0] rsp0_data_q, rsp0_data_d;
    logic [LUT_DW-1:0] rsp1_data_q, rsp1_data_d;

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_hs;
    logic              accept;
    req_id_t           acc_id;
    logic [LUT_DW-1:0] scaled;

    cry_scale u_scale (
        .rom_z (rom_z),
        .y     (s2_y_q),
        .data  (scaled)
    );

    // Arbitration: busy holds a requester off from accept until its response is consumed,
    // which also keeps a response slot reserved so the pipeline never stalls.
    always_comb begin
        elig = {req1_valid & ~busy_q[1], req0_valid & ~busy_q[0]};
        gnt  = elig;
        if (elig == 2'b11) begin
            gnt = (last_q == req_id_t'(1)) ? 2'b01 : 2'b10;
        end
        if (!reset_n) begin
            gnt = 2'b00;
        end
        accept = |gnt;
        acc_id = req_id_t'(gnt[1]);
        rsp_hs = rsp_valid_q & {rsp1_ready, rsp0_ready};
    end

    always_comb begin
        busy_d      = (busy_q | gnt) & ~rsp_hs;
        last_d      = accept ? acc_id : last_q;

        // Stage 1: rom_a is presented while the lookup sits here; it holds when empty.
        s1_valid_d  = accept;
        s1_id_d     = accept ? acc_id : s1_id_q;
        s1_y_d      = s1_y_q;
        rom_a_d     = rom_a_q;
        if (gnt[0]) begin
            s1_y_d  = req0_y;
            rom_a_d = req0_cr;
        end else if (gnt[1]) begin
            s1_y_d  = req1_y;
            rom_a_d = req1_cr;
        end

        // Stage 2 lines y up with the registered ROM output one cycle later.
        s2_valid_d  = s1_valid_q;
        s2_id_d     = s1_id_q;
        s2_y_d      = s1_y_q;

        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;
        if (s2_valid_q) begin
            rsp_valid_d[s2_id_q] = 1'b1;
            if (s2_id_q == req_id_t'(0)) begin
                rsp0_data_d = scaled;
            end else begin
                rsp1_data_d = scaled;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            last_q      <= req_id_t'(1);
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_y_q      <= '0;
            rom_a_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_y_q      <= '0;
            rsp_valid_q <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            busy_q      <= busy_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_y_q      <= s1_y_d;
            rom_a_q     <= rom_a_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            s2_y_q      <= s2_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign rom_a      = rom_a_q;

endmodule

// File: tb/tb_cry_lut_arb.sv
// tb/tb_cry_lut_arb.sv - self-checking bench for cry_lut_arb with a registered ROM model
module tb_cry_lut_arb;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_cr = 8'h00, req0_y = 8'h00, req1_cr = 8'h00, req1_y = 8'h00;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] rom_a;
    logic [7:0] rom_z = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int acc0 = 0, acc1 = 0;

    cry_lut_arb dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cr    (req0_cr),
        .req0_y     (req0_y),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cr    (req1_cr),
        .req1_y     (req1_y),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rom_a      (rom_a),
        .rom_z      (rom_z)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        if (a == 8'h80) return 8'hFF;
        if (a == 8'h2D) return 8'h2B;
        return a ^ 8'hA5;
    endfunction

    always @(posedge sys_clk) rom_z <= rom_val(rom_a);

    function automatic logic [7:0] exp_data(input logic [7:0] cr, input logic [7:0] y);
        int p;
        p = int'(rom_val(cr)) * (int'(y) + 1);
        return 8'(p / 256);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    // Scoreboard: push expected data at accept, pop and compare at response handshake.
    task automatic monitor();
        logic pv0, pv1;
        logic [7:0] e;
        pv0 = 1'b0;
        pv1 = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                q0.delete();
                q1.delete();
                pv0 = 1'b0;
                pv1 = 1'b0;
            end else begin
                tests_run++;
                if (req0_ready && req1_ready) begin
                    tests_failed++;
                    $display("FAIL double_grant cyc=%0d: both readys high, required at most one", cyc);
                end
                if (req0_valid && req0_ready) begin q0.push_back(exp_data(req0_cr, req0_y)); acc0 = cyc; end
                if (req1_valid && req1_ready) begin q1.push_back(exp_data(req1_cr, req1_y)); acc1 = cyc; end
                if (rsp0_valid && !pv0) begin
                    tests_run++;
                    if (cyc - acc0 != 3) begin
                        tests_failed++;
                        $display("FAIL latency0: got %0d, required 3", cyc - acc0);
                    end
                end
                if (rsp1_valid && !pv1) begin
                    tests_run++;
                    if (cyc - acc1 != 3) begin
                        tests_failed++;
                        $display("FAIL latency1: got %0d, required 3", cyc - acc1);
                    end
                end
                if (rsp0_valid && rsp0_ready) begin
                    tests_run++;
                    if (q0.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_rsp0: data %h with no outstanding lookup", rsp0_data);
                    end else begin
                        e = q0.pop_front();
                        if (rsp0_data !== e) begin
                            tests_failed++;
                            $display("FAIL rsp0_data: got %h, required %h", rsp0_data, e);
                        end
                    end
                end
                if (rsp1_valid && rsp1_ready) begin
                    tests_run++;
                    if (q1.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_rsp1: data %h with no outstanding lookup", rsp1_data);
                    end else begin
                        e = q1.pop_front();
                        if (rsp1_data !== e) begin
                            tests_failed++;
                            $display("FAIL rsp1_data: got %h, required %h", rsp1_data, e);
                        end
                    end
                end
                pv0 = rsp0_valid;
                pv1 = rsp1_valid;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_cr = 8'h12; req0_y = 8'h34;
        req1_valid = 1'b1; req1_cr = 8'h56; req1_y = 8'h78;
        repeat (2) tick();
        @(negedge sys_clk);
        tests_run += 7;
        if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req0_ready: got %b, required 0", req0_ready); end
        if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req1_ready: got %b, required 0", req1_ready); end
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp0_valid: got %b, required 0", rsp0_valid); end
        if (rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp1_valid: got %b, required 0", rsp1_valid); end
        if (rsp0_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp0_data: got %h, required 00", rsp0_data); end
        if (rsp1_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp1_data: got %h, required 00", rsp1_data); end
        if (rom_a !== 8'h00) begin tests_failed++; $display("FAIL reset_rom_a: got %h, required 00", rom_a); end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        tick();
        req0_valid = 1'b1; req0_cr = 8'h80; req0_y = 8'hFF;
        @(negedge sys_clk);
        tests_run++;
        if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL single_accept: req0_ready %b, required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        @(negedge sys_clk);
        tests_run += 2;
        if (rom_a !== 8'h80) begin tests_failed++; $display("FAIL single_rom_a: got %h, required 80", rom_a); end
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_t1: rsp0_valid %b, required 0", rsp0_valid); end
        @(negedge sys_clk);
        tests_run++;
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_t2: rsp0_valid %b, required 0", rsp0_valid); end
        @(negedge sys_clk);
        tests_run += 2;
        if (rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid_t3: rsp0_valid %b, required 1", rsp0_valid); end
        if (rsp0_data !== 8'hFF) begin tests_failed++; $display("FAIL single_data: got %h, required FF", rsp0_data); end
        @(negedge sys_clk);
        tests_run++;
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_consumed: rsp0_valid %b, required 0", rsp0_valid); end
    endtask

    task automatic test_scale();
        logic [7:0] ys [0:2];
        logic [7:0] es [0:2];
        logic found;
        ys = '{8'h00, 8'h7F, 8'hFF};
        es = '{8'h00, 8'h15, 8'h2B};
        for (int i = 0; i < 3; i++) begin
            tick();
            req1_valid = 1'b1; req1_cr = 8'h2D; req1_y = ys[i];
            @(negedge sys_clk);
            tests_run++;
            if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL scale_accept%0d: req1_ready %b, required 1", i, req1_ready); end
            tick();
            req1_valid = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                @(negedge sys_clk);
                if (rsp1_valid) begin
                    found = 1'b1;
                    tests_run++;
                    if (rsp1_data !== es[i]) begin
                        tests_failed++;
                        $display("FAIL scale_y%h: got %h, required %h", ys[i], rsp1_data, es[i]);
                    end
                end
            end
            tests_run++;
            if (!found) begin tests_failed++; $display("FAIL scale_timeout%0d: rsp1_valid 0, required 1", i); end
        end
    endtask

    task automatic test_tie();
        logic [8:0] e0, e1;
        e0 = 9'b100010001;
        e1 = 9'b000100010;
        reset_n = 1'b0;
        repeat (2) tick();
        req0_valid = 1'b1; req0_cr = 8'h11; req0_y = 8'h40;
        req1_valid = 1'b1; req1_cr = 8'h2D; req1_y = 8'h7F;
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            tests_run++;
            if ({req1_ready, req0_ready} !== {e1[i], e0[i]}) begin
                tests_failed++;
                $display("FAIL tie_grant cyc%0d: ready1/0 %b%b, required %b%b", i, req1_ready, req0_ready, e1[i], e0[i]);
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] expd;
        logic found;
        int n1;
        expd = exp_data(8'h33, 8'h90);
        rsp0_ready = 1'b0;
        tick();
        req0_valid = 1'b1; req0_cr = 8'h33; req0_y = 8'h90;
        @(negedge sys_clk);
        tests_run++;
        if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept: req0_ready %b, required 1", req0_ready); end
        tick();
        req0_cr = 8'h34;
        req1_valid = 1'b1; req1_cr = 8'h5A; req1_y = 8'hC0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge sys_clk);
            if (rsp0_valid) found = 1'b1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL bp_timeout: rsp0_valid 0, required 1"); end
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge sys_clk);
            tests_run += 3;
            if (rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold%0d: got %b, required 1", i, rsp0_valid); end
            if (rsp0_data !== expd) begin tests_failed++; $display("FAIL bp_data_hold%0d: got %h, required %h", i, rsp0_data, expd); end
            if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_req0_ready%0d: got %b, required 0", i, req0_ready); end
            if (req1_valid && req1_ready) n1++;
        end
        tests_run++;
        if (n1 < 2) begin tests_failed++; $display("FAIL bp_req1_served: %0d accepts, required at least 2", n1); end
        tick();
        rsp0_ready = 1'b1;
        @(negedge sys_clk);
        tests_run += 2;
        if (rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hs_valid: got %b, required 1", rsp0_valid); end
        if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_same_cycle: req0_ready %b, required 0", req0_ready); end
        @(negedge sys_clk);
        tests_run++;
        if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_next_cycle: req0_ready %b, required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        tick();
        req0_valid = 1'b1; req0_cr = 8'h44; req0_y = 8'h22;
        @(negedge sys_clk);
        tests_run++;
        if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_accept: req0_ready %b, required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        req1_valid = 1'b1; req1_cr = 8'h66; req1_y = 8'h99;
        @(negedge sys_clk);
        tests_run += 6;
        if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_req1_ready: got %b, required 0", req1_ready); end
        if (rom_a !== 8'h00) begin tests_failed++; $display("FAIL mid_rom_a: got %h, required 00", rom_a); end
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rsp0_valid: got %b, required 0", rsp0_valid); end
        if (rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rsp1_valid: got %b, required 0", rsp1_valid); end
        if (rsp0_data !== 8'h00) begin tests_failed++; $display("FAIL mid_rsp0_data: got %h, required 00", rsp0_data); end
        if (rsp1_data !== 8'h00) begin tests_failed++; $display("FAIL mid_rsp1_data: got %h, required 00", rsp1_data); end
        tick();
        reset_n = 1'b1;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            tests_run++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_stale_rsp%0d: rsp valids %b%b, required 00", i, rsp1_valid, rsp0_valid);
            end
        end
        tick();
        req0_valid = 1'b1; req0_cr = 8'h21; req0_y = 8'h10;
        req1_valid = 1'b1; req1_cr = 8'h22; req1_y = 8'h20;
        @(negedge sys_clk);
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_tie: ready1/0 %b%b, required 01", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (q0.size() != 0 || q1.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d/%0d lookups unanswered, required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_scale();
        test_tie();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cry_lut_arb.md
CRY_LUT_ARB -- requirements
Module: cry_lut_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL declare ports in the order listed in REQ-002 to REQ-015.
REQ-002 sys_clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 req0_valid  in  1  requester 0 has a lookup pending.
REQ-005 req0_ready  out  1  requester 0 lookup accepted this cycle when high together with req0_valid.
REQ-006 req0_cr  in  8  requester 0 CRY colour index {C[3:0],R[3:0]}.
REQ-007 req0_y  in  8  requester 0 intensity.
REQ-008 rsp0_valid  out  1  requester 0 result available.
REQ-009 rsp0_ready  in  1  requester 0 consumes the result.
REQ-010 rsp0_data  out  8  requester 0 scaled component.
REQ-011 req1_valid, req1_ready, req1_cr, req1_y, rsp1_valid, rsp1_ready, rsp1_data: as REQ-004 to REQ-010 for requester 1.
REQ-012 rom_a  out  8  address to the shared 256x8 CRY component ROM.
REQ-013 rom_z  in  8  ROM data, valid one sys_clk after rom_a is presented, because the ROM output is registered.
REQ-014 Constants: NREQ = 2; LUT_AW = 8; LUT_DW = 8; all constants come from the shared package.
REQ-015 The block SHALL have no other ports.

Function
REQ-016 Eligibility: requester N is eligible when reqN_valid=1 and busyN=0; busyN means one lookup is outstanding or unconsumed.
REQ-017 Arbitration: at most one grant per cycle, chosen round-robin.
- Only one eligible requester: it wins.
- Both eligible: the requester not granted last wins.
- The last-grant pointer updates only on an accepted handshake.
REQ-018 reqN_ready SHALL be combinational and high only for the granted requester; it is never high when busyN=1.
REQ-019 An accept at cycle T SHALL set busyN and capture {id, cr, y} into stage 1 at the end of T; rom_a = cr during T+1.
REQ-020 Stage 2 SHALL carry {id, y} at the end of T+1 so that it aligns with rom_z during T+2.
REQ-021 Result formula:
- data = (rom_z * (y + 1)) >> 8, using a 9-bit by 8-bit product truncated to 8 bits.
- y = 0xFF returns rom_z unchanged; y = 0 returns 0.
REQ-022 The result SHALL be registered into response register id at the end of T+2, with rspN_valid high from T+3 (fixed latency 3).
REQ-023 rspN_valid and rspN_data SHALL hold stable until rspN_ready=1; the handshake clears rspN_valid and busyN at the end of that cycle.
REQ-024 A requester SHALL NOT be accepted in the same cycle its response handshake completes; it becomes eligible the following cycle.
REQ-025 Throughput: maximum one accept per cycle overall and one accept per 4 cycles per requester.
REQ-026 The pipeline SHALL never stall, because a response slot is reserved at accept.
REQ-027 rom_a SHALL hold its last value when stage 1 is empty.
REQ-028 Requests present during reset SHALL NOT be accepted; the first accept can occur in the first cycle after reset_n deasserts.

Reset
REQ-029 Assertion of reset_n=0 SHALL asynchronously clear the following state, discarding any in-flight lookups:
- busy0 and busy1;
- stage 1 and stage 2 valid flags;
- rsp0_valid and rsp1_valid;
- rsp0_data and rsp1_data to 0x00;
- rom_a to 0x00;
- the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-030 reqN_ready SHALL be 0 while reset_n=0.

Structure
REQ-031 The shared package cry_pkg SHALL hold NREQ, LUT_AW, LUT_DW, the latency constant (3), and the requester-id type.
REQ-032 The scaling multiply SHALL be a sub-module cry_scale (rom_z, y -> data, combinational); the arbiter, pipeline and response registers stay in cry_lut_arb.
REQ-033 The ROM SHALL be external to this block and connected through rom_a/rom_z.

Verification
REQ-034 Single lookup: req0 cr=0x80, y=0xFF accepted at T -> rom_a=0x80 at T+1; rsp0_valid at T+3 with data=0xFF.
REQ-035 Scaling: req1 cr=0x2D (ROM 0x2B) with y=0x00 -> data 0x00; with y=0x7F -> data 0x15; with y=0xFF -> data 0x2B.
REQ-036 Tie sequence: both requesters valid continuously from the first cycle after reset, responses consumed immediately.
- Grant order: 0, 1, then 0 again no earlier than 4 cycles after its first accept.
- No double grant in any cycle.
REQ-037 Backpressure: rsp0_ready=0 for 10 cycles.
- rsp0_valid and rsp0_data stay stable for all 10 cycles.
- req0_ready stays 0 for all 10 cycles.
- Requester 1 continues to be served.
- After the rsp0 handshake, requester 0 is accepted no earlier than the next cycle.
REQ-038 Reset mid-operation: reset_n low for 1 cycle at T+2 of an accept.
- All outputs return to reset values.
- No rsp_valid appears afterwards.
- The next tie grants requester 0.
